stat_accum: RTL

STAT_ACCUM -- requirements
Module: stat_accum

---
 rtl/stat_accum.sv | 131 +++++++++++++
 1 files changed

// File: rtl/stat_accum.sv
// stat_accum: per-frame statistics over samples pulled from an upstream FIFO.
// A frame is requested with start_i/frame_len_i. The block reads frame_len_i
// samples at up to one per cycle and accumulates sum, min, max and count. The
// result is then held on a valid/ready handshake until it is accepted.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, frame_len_i    frame request and its length (zero length ignored)
//   fifo_empty_i            upstream FIFO empty flag
//   fifo_rd_en_o            upstream FIFO read enable (combinational)
//   fifo_data_i             FIFO data, valid the cycle after an accepted read
//   res_valid_o/res_ready_i result handshake
//   res_sum_o, res_min_o, res_max_o, res_cnt_o  frame statistics
//   busy_o                  high whenever a frame is in progress or pending
module stat_accum #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH = 10,
  parameter int unsigned SUM_WIDTH = D_WIDTH + CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] frame_len_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  input  logic [D_WIDTH-1:0]   fifo_data_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [SUM_WIDTH-1:0] res_sum_o,
  output logic [D_WIDTH-1:0]   res_min_o,
  output logic [D_WIDTH-1:0]   res_max_o,
  output logic [CNT_WIDTH-1:0] res_cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 start_ok;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] issued_q;
  logic                 rd_q;

  // Reads stop once every sample of the frame has been requested.
  assign fifo_rd_en_o = (state_q == RUN) && !fifo_empty_i && (issued_q < len_q);

  // Next-state logic; DONE is entered on the edge that accumulates the last sample.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (frame_len_i != '0)) begin
          start_ok = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (rd_q && (CNT_WIDTH'(res_cnt_o + CNT_WIDTH'(1)) == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_valid_o && res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_valid_o <= (state_d == DONE);
      busy_o      <= (state_d != IDLE);
    end
  end

  // Frame length, issued-read counter and the one-cycle read-return flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q    <= '0;
      issued_q <= '0;
      rd_q     <= 1'b0;
    end else begin
      rd_q <= fifo_rd_en_o;
      if (start_ok) begin
        len_q    <= frame_len_i;
        issued_q <= '0;
      end else if (fifo_rd_en_o) begin
        issued_q <= issued_q + CNT_WIDTH'(1);
      end
    end
  end

  // Accumulators double as the result registers, so they hold after DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_sum_o <= '0;
      res_min_o <= '0;
      res_max_o <= '0;
      res_cnt_o <= '0;
    end else if (start_ok) begin
      res_sum_o <= '0;
      res_min_o <= '1;
      res_max_o <= '0;
      res_cnt_o <= '0;
    end else if (rd_q) begin
      res_sum_o <= res_sum_o + SUM_WIDTH'(fifo_data_i);
      if (fifo_data_i < res_min_o) begin
        res_min_o <= fifo_data_i;
      end
      if (fifo_data_i > res_max_o) begin
        res_max_o <= fifo_data_i;
      end
      res_cnt_o <= res_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule
